// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and constants for the CPU execute controller
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_PAUSE = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;
  localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;
  localparam int RET_W = 32;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divider whose terminal count marks the cycle a tick would be issued
module tick_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div_sel,
  output logic             o_tc
);
  logic [DIV_W-1:0] r_cnt;
  assign o_tc = r_cnt == i_div_sel;
  always_ff @(posedge clk) r_cnt <= (rst || i_clr) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: run/step/halt sequencer for the CPU; define CPU_EXEC_CTRL_BREAKPOINT_EN to add a PC breakpoint
module cpu_exec_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int         DIV_W       = 24,
  parameter int         RST_CYCLES  = 4,
  parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             restart,
  input  logic [DIV_W-1:0] div_sel,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
  input  logic             bp_valid,
  input  logic [31:0]      bp_addr,
  output logic             bp_hit,
`endif
  output logic             cpu_tick,
  output logic             cpu_reset,
  output logic [2:0]       state,
  output logic             halted,
  output logic [RET_W-1:0] retired
);
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  state_t           r_state;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [RET_W-1:0] r_retired;
  logic             r_step_q, r_tick, r_reset, r_halted;
  logic             w_tc, w_clr, w_step_edge, w_halt_op, w_bp, w_hold, w_unused;
  assign w_step_edge = step_btn & ~r_step_q;
  assign w_halt_op   = instr[31:26] == HALT_OPCODE;
  // the divider only advances while actually free-running; any tick, stop or exit restarts it
  assign w_clr = restart || r_state != ST_RUN || !run_sw || w_tc;
  tick_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk       (CLK),
    .rst       (reset),
    .i_clr     (w_clr),
    .i_div_sel (div_sel),
    .o_tc      (w_tc)
  );
`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
  logic r_bp_hold, r_bp_hit, w_bp_set;
  assign w_bp     = bp_valid && pc == bp_addr;
  assign w_hold   = r_bp_hold;
  assign w_bp_set = r_state == ST_RUN && run_sw && w_tc && !w_halt_op && w_bp;
  assign bp_hit   = r_bp_hit;
  assign w_unused = ^instr[25:0];
  always_ff @(posedge CLK) begin
    r_bp_hit  <= (reset || restart) ? 1'b0 : w_bp_set;
    r_bp_hold <= (reset || restart) ? 1'b0 : w_bp_set || (r_bp_hold && run_sw && r_state != ST_STEP);
  end
`else
  assign w_bp     = 1'b0;
  assign w_hold   = 1'b0;
  assign w_unused = ^{instr[25:0], pc};
`endif
  always_ff @(posedge CLK) begin
    r_step_q <= reset ? 1'b0 : step_btn;
    if (reset || restart) begin
      r_state   <= ST_RST;
      r_rst_cnt <= '0;
      r_retired <= '0;
      r_reset   <= 1'b1;
      r_tick    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_tick   <= 1'b0;
      r_reset  <= 1'b0;
      r_halted <= 1'b0;
      case (r_state)
        ST_RST: begin
          r_tick  <= 1'b1;
          r_reset <= 1'b1;
          if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            r_state   <= ST_PAUSE;
            r_rst_cnt <= '0;
          end else r_rst_cnt <= r_rst_cnt + 1'b1;
        end
        ST_PAUSE:
          if (run_sw && !w_hold) r_state <= ST_RUN;
          else if (w_step_edge) r_state <= ST_STEP;
        ST_RUN:
          if (!run_sw) r_state <= ST_PAUSE;
          else if (w_tc) begin
            if (w_halt_op) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else if (w_bp) r_state <= ST_PAUSE;
            else begin
              r_tick    <= 1'b1;
              r_retired <= r_retired + RET_W'(~&r_retired);
            end
          end
        ST_STEP:
          if (w_halt_op) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state   <= ST_PAUSE;
            r_tick    <= 1'b1;
            r_retired <= r_retired + RET_W'(~&r_retired);
          end
        ST_HALT: r_halted <= 1'b1;
        default: r_state <= ST_RST;
      endcase
    end
  end
  assign cpu_tick  = r_tick;
  assign cpu_reset = r_reset;
  assign state     = r_state;
  assign halted    = r_halted;
  assign retired   = r_retired;
endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// tb_cpu_exec_ctrl: scoreboard bench checking tick timing, reset, step, halt and pause races
module tb_cpu_exec_ctrl;
  logic        CLK = 1'b0;
  logic        reset, run_sw, step_btn, restart;
  logic [23:0] div_sel;
  logic [31:0] pc, instr;
  logic        cpu_tick, cpu_reset, halted;
  logic [2:0]  state;
  logic [31:0] retired;
`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
  logic        bp_valid, bp_hit;
  logic [31:0] bp_addr;
`endif
  int n_tests = 0, n_fail = 0, cyc = 0, rst_ticks = 0, e, t, r0;
  int exp_q[$];
  cpu_exec_ctrl dut (
    .CLK       (CLK),
    .reset     (reset),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .restart   (restart),
    .div_sel   (div_sel),
    .pc        (pc),
    .instr     (instr),
`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
    .bp_valid  (bp_valid),
    .bp_addr   (bp_addr),
    .bp_hit    (bp_hit),
`endif
    .cpu_tick  (cpu_tick),
    .cpu_reset (cpu_reset),
    .state     (state),
    .halted    (halted),
    .retired   (retired)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  always @(negedge CLK) begin
    if (cpu_tick && cpu_reset) rst_ticks++;
    if (cpu_tick && !cpu_reset) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : -1;
      check("tick_at_cycle", 64'(cyc), 64'(e));
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1; run_sw = 0; step_btn = 0; restart = 0;
    div_sel = 3; pc = 0; instr = 0;
`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
    bp_valid = 0; bp_addr = 32'h10;
`endif
    step(2);
    check("rst_state", state, 0);
    check("rst_tick", cpu_tick, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_retired", retired, 0);
    check("rst_halted", halted, 0);
    reset = 0;
    step(6);
    check("rel_reset_ticks", rst_ticks, 4);
    check("rel_state", state, 1);
    check("rel_cpu_reset", cpu_reset, 0);
    check("rel_retired", retired, 0);
    // free-run, div_sel=3: first tick two cycles after run_sw plus four counts
    t = cyc; run_sw = 1;
    for (int k = 0; k < 10; k++) exp_q.push_back(t + 5 + 4 * k);
    step(42);
    run_sw = 0;
    step(2);
    check("run_state", state, 1);
    check("run_retired", retired, 10);
    check("run_q_empty", exp_q.size(), 0);
    // single step with a long prescale and a long button hold
    div_sel = 100; t = cyc; step_btn = 1;
    exp_q.push_back(t + 2);
    step(1);
    check("step_state", state, 3);
    step(19);
    step_btn = 0;
    step(2);
    check("step_back_pause", state, 1);
    check("step_retired", retired, 11);
    check("step_q_empty", exp_q.size(), 0);
    // run and step edge together: run wins, held button is not replayed on pause
    div_sel = 3; t = cyc; run_sw = 1; step_btn = 1;
    exp_q.push_back(t + 5); exp_q.push_back(t + 9);
    step(9);
    run_sw = 0;
    step(5);
    check("race_state", state, 1);
    check("race_retired", retired, 13);
    check("race_q_empty", exp_q.size(), 0);
    step_btn = 0;
    step(1);
    // run_sw drops on the terminal-count cycle
    t = cyc; run_sw = 1;
    exp_q.push_back(t + 5); exp_q.push_back(t + 9);
    step(12);
    run_sw = 0;
    step(1);
    check("prace_state", state, 1);
    check("prace_div_cnt", dut.u_pre.r_cnt, 0);
    step(3);
    check("prace_retired", retired, 15);
    check("prace_q_empty", exp_q.size(), 0);
    // halt opcode stops execution without a tick
    div_sel = 0; instr = 32'hFC00_0000; run_sw = 1;
    step(2);
    check("halt_state", state, 4);
    check("halt_flag", halted, 1);
    check("halt_tick", cpu_tick, 0);
    step_btn = 1;
    step(3);
    step_btn = 0;
    step(2);
    check("halt_sticky", state, 4);
    check("halt_retired", retired, 15);
    r0 = rst_ticks; restart = 1;
    step(1);
    restart = 0; run_sw = 0; instr = 0;
    check("restart_state", state, 0);
    check("restart_retired", retired, 0);
    check("restart_halted", halted, 0);
    check("restart_cpu_reset", cpu_reset, 1);
    step(5);
    check("restart_reset_ticks", rst_ticks - r0, 4);
    check("restart_pause", state, 1);
`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
    pc = 32'h10; bp_valid = 1; div_sel = 0; run_sw = 1;
    step(2);
    check("bp_hit_pulse", bp_hit, 1);
    check("bp_state", state, 1);
    step(1);
    check("bp_hit_drop", bp_hit, 0);
    step(4);
    check("bp_run_blocked", state, 1);
    t = cyc; step_btn = 1;
    exp_q.push_back(t + 2); exp_q.push_back(t + 4);
    exp_q.push_back(t + 5); exp_q.push_back(t + 6);
    step(2);
    pc = 32'h14; step_btn = 0;
    check("bp_step_pause", state, 1);
    step(2);
    check("bp_resume_run", state, 2);
    step(2);
    run_sw = 0;
    step(2);
    check("bp_end_state", state, 1);
    check("bp_retired", retired, 4);
    check("bp_q_empty", exp_q.size(), 0);
`endif
    step(3);
    check("final_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_exec_ctrl.md
Name: cpu_exec_ctrl

Overview:
- Run/step/halt sequencer for the single-cycle CPU.
- Replaces the free-running slowed clock with a one-cycle execute enable, `cpu_tick`, generated on the fast clock `CLK`. Every CPU state element (PC, register file, RAM write) advances only when `cpu_tick` is high.
- Also generates the CPU reset pulse and counts retired instructions.
- Sits between board switches/buttons and the CPU top.

Parameters:
- DIV_W, 24, width of the prescaler counter and of `div_sel`.
- RST_CYCLES, 4, number of CLK cycles `cpu_reset` is held high after reset or restart.
- HALT_OPCODE, 6'b111111, value of `instr[31:26]` that stops execution.

Ports:
- CLK  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run_sw  in  1  level; 1 = free-run, 0 = pause.
- step_btn  in  1  already synchronized and debounced; rising edge requests one step.
- restart  in  1  one-cycle pulse; re-enters reset sequence.
- div_sel  in  DIV_W  prescaler terminal count; tick period is `div_sel`+1 cycles.
- pc  in  32  current CPU PC.
- instr  in  32  current instruction word.
- cpu_tick  out  1  one-cycle execute enable to the CPU.
- cpu_reset  out  1  CPU reset; loads resetPC on `cpu_tick`.
- state  out  3  FSM encoding: RST=0, PAUSE=1, RUN=2, STEP=3, HALT=4.
- halted  out  1  high while in HALT.
- retired  out  32  count of `cpu_tick` pulses with `cpu_reset` low; saturating.

Behaviour:
- Clock and reset
  - One clock, `CLK`; `reset` is synchronous and active-high.
  - Reset values: state=RST, rst_cnt=0, div_cnt=0, retired=0, step_q=0, cpu_reset=1, cpu_tick=0, halted=0.
  - Outputs are registered: the decision made in cycle N appears in cycle N+1.
- RST state
  - cpu_reset=1 and cpu_tick=1 every cycle, so the CPU's edge-registered reset takes effect.
  - rst_cnt counts up; when rst_cnt==RST_CYCLES-1, go to PAUSE and clear rst_cnt.
  - retired is held at 0.
- PAUSE state
  - No ticks.
  - run_sw=1 → RUN with div_cnt cleared.
  - Otherwise, a step edge (step_btn & ~step_q) → STEP.
  - If both run_sw=1 and a step edge occur, RUN wins and the step edge is discarded.
- RUN state
  - div_cnt increments each cycle.
  - On div_cnt==div_sel: emit tick and clear div_cnt. div_sel=0 gives a tick every cycle.
  - run_sw=0 → PAUSE in the same cycle; no tick is emitted even at terminal count, and div_cnt is cleared.
- STEP state
  - Exactly one tick, then PAUSE.
  - Lasts one cycle regardless of div_sel.
- HALT detection
  - Applies in RUN or STEP: if instr[31:26]==HALT_OPCODE at the cycle a tick would be issued, suppress the tick and go to HALT.
  - The PC therefore stays at the halt instruction.
- HALT state
  - halted=1, no ticks; run_sw and step_btn are ignored.
  - Exit only via restart or reset.
- restart
  - From any state → RST next cycle; div_cnt and retired are cleared.
  - restart has priority over all other inputs except reset.
- retired
  - Increments on each emitted tick outside RST.
  - Stops at 32'hFFFF_FFFF (no wrap).
- step_q
  - Registers step_btn every cycle in every state, so an edge held across RUN→PAUSE is not replayed.
- Mid-operation changes
  - div_sel changed during RUN takes effect immediately.
  - If div_cnt is already greater than the new div_sel, the counter wraps at 2^DIV_W. This is accepted behaviour, not an error.

Optional Feature:
- Macro: CPU_EXEC_CTRL_BREAKPOINT_EN.
- Defined:
  - Adds ports `bp_valid` (in, 1), `bp_addr` (in, 32) and `bp_hit` (out, 1).
  - In RUN, if bp_valid && pc==bp_addr at a would-be tick: no tick, go to PAUSE, set bp_hold=1, bp_hit=1 for one cycle.
  - While bp_hold=1, PAUSE→RUN is blocked.
  - bp_hold clears when run_sw=0 or when a STEP is taken. A STEP executes the breakpointed instruction.
  - HALT_OPCODE check has priority over the breakpoint.
- Undefined: these ports and the bp_hold logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `cpu_ctrl_pkg`:
  - state encoding constants (ST_RST..ST_HALT);
  - HALT opcode default;
  - the 32-bit retired-count width constant.
- One sub-module is natural: `tick_prescaler` (div_cnt, terminal-count compare, clear input).
- FSM, edge detect and counters stay in the top.

Test Plan:
- Reset release: reset for 2 cycles, run_sw=0 → cpu_reset=1 with cpu_tick=1 for exactly 4 cycles, then state=1, no ticks, retired=0.
- Free-run: div_sel=3, run_sw=1, non-halt instr → tick every 4th cycle; after 40 cycles retired=10.
- Single step: PAUSE with div_sel=100, one step_btn rising edge held 20 cycles → exactly 1 tick, retired+=1, state returns to 1.
- Halt: RUN with div_sel=0, instr=32'hFC00_0000 → no tick that cycle, state=4, halted=1; step/run ignored; restart pulse → state=0, retired=0.
- Pause race: run_sw drops on the terminal-count cycle → no tick, state=1, div_cnt=0.
- BREAKPOINT_EN: bp_addr=32'h0000_0010, pc reaches 0x10 → bp_hit pulse, no tick, state=1 even with run_sw=1; one step → tick, then run_sw=1 → RUN resumes.
